// File: rtl/stream_demux_rr.sv
// Round-robin stream demultiplexer: one valid/ready input spread over N
// one-entry output buffers. Define STREAM_DEMUX_RR_SKIP_EN for work-conserving mode.
module stream_demux_rr #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    input  logic [W-1:0]         up_data,
    output logic                 up_ready,
    output logic [N-1:0]         dn_valid,
    output logic [N*W-1:0]       dn_data,
    input  logic [N-1:0]         dn_ready,
    output logic [$clog2(N)-1:0] ptr
);
    localparam int PW = $clog2(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [N-1:0]  full;
    logic [W-1:0]  store [N];
    logic [N-1:0]  can;
    logic [PW-1:0] target;
    logic [PW-1:0] ptr_next;
    logic          accept;

    // A slot accepts when empty or being drained in the same cycle
    assign can = ~full | dn_ready;

`ifdef STREAM_DEMUX_RR_SKIP_EN
    int            idx;
    logic [PW-1:0] cand;

    // First acceptable channel scanning cyclically from ptr
    always_comb begin
        target   = ptr;
        up_ready = |can;
        idx      = 0;
        cand     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = PW'(idx);
            if (can[cand]) begin
                target = cand;
            end
        end
    end
`else
    assign target   = ptr;
    assign up_ready = can[ptr];
`endif

    assign accept   = up_valid & up_ready;
    assign ptr_next = (target == LAST) ? '0 : target + 1'b1;

    // Slot occupancy, payload registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
            ptr  <= '0;
            for (int i = 0; i < N; i++) begin
                store[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (full[i] && dn_ready[i]) begin
                    full[i] <= 1'b0;
                end
            end
            if (accept) begin
                full[target]  <= 1'b1;
                store[target] <= up_data;
                ptr           <= ptr_next;
            end
        end
    end

    assign dn_valid = full;

    for (genvar g = 0; g < N; g++) begin : g_out
        assign dn_data[g*W +: W] = store[g];
    end

endmodule
